// File: rtl/cnn_result_buffer.sv
// cnn_result_buffer
//   Captures one frame of N-bit result words from cnn_block into a local
//   buffer. The frame is closed by the end strobe. A reader then drains the
//   words in arrival order with a pop handshake. Capture re-arms once the
//   last word has been popped.
//
// Ports
//   clk          clock, all state on rising edge
//   global_rst   asynchronous active-high reset
//   ce           clock enable; low freezes all state and suppresses rd_valid
//   data_in      result word
//   valid_in     data_in valid this cycle
//   end_in       last word of the frame (may coincide with valid_in)
//   rd_en        pop request
//   rd_data      popped word (registered)
//   rd_valid     one-cycle pulse qualifying rd_data
//   frame_done   a complete frame is waiting for, or undergoing, draining
//   word_count   number of words currently held
//   overflow     sticky flag: a word was dropped
module cnn_result_buffer #(
  parameter int N     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          global_rst,
  input  logic          ce,
  input  logic [N-1:0]  data_in,
  input  logic          valid_in,
  input  logic          end_in,
  input  logic          rd_en,
  output logic [N-1:0]  rd_data,
  output logic          rd_valid,
  output logic          frame_done,
  output logic [AW:0]   word_count,
  output logic          overflow
);

  typedef enum logic {CAPTURE, READY} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t         state, state_next;
  logic [N-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;

  logic           wr_fire;
  logic           pop;
  logic           last_pop;
  logic           drop;

  // Next-state and per-cycle action decode.
  always_comb begin
    state_next = state;
    wr_fire    = 1'b0;
    pop        = 1'b0;
    last_pop   = 1'b0;
    drop       = 1'b0;
    if (ce) begin
      unique case (state)
        CAPTURE: begin
          if (valid_in) begin
            if (count != FULL) wr_fire = 1'b1;
            else               drop    = 1'b1;
          end
          // The end strobe only closes a frame that holds at least one word,
          // counting a word written in the same cycle.
          if (end_in && ((count != '0) || wr_fire))
            state_next = READY;
        end
        READY: begin
          drop = valid_in;
          if (rd_en && (count != '0)) begin
            pop = 1'b1;
            if (count == ONE) begin
              last_pop   = 1'b1;
              state_next = CAPTURE;
            end
          end
        end
        default: state_next = CAPTURE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) state <= CAPTURE;
    else            state <= state_next;
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (drop) overflow <= 1'b1;
      // Writes only happen in CAPTURE and pops only in READY, so the two
      // never coincide.
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (pop) begin
        rd_data <= mem[rd_ptr];
        count   <= count - 1'b1;
        if (last_pop) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // Storage carries no reset; contents are only observable after a write.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= data_in;
  end

  assign frame_done = (state == READY);
  assign word_count = count;

endmodule

// File: tb/tb_cnn_result_buffer.sv
module tb_cnn_result_buffer;

  localparam int N     = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          global_rst = 1'b1;
  logic          ce = 1'b0;
  logic [N-1:0]  data_in = '0;
  logic          valid_in = 1'b0;
  logic          end_in = 1'b0;
  logic          rd_en = 1'b0;
  logic [N-1:0]  rd_data;
  logic          rd_valid;
  logic          frame_done;
  logic [AW:0]   word_count;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: held frame as a queue, plus mode and sticky flag.
  logic [N-1:0] mq[$];
  logic         m_ready = 1'b0;
  logic         m_ovf   = 1'b0;
  // Scoreboard of words the reader must see, in order.
  logic [N-1:0] exp_q[$];

  cnn_result_buffer #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .global_rst (global_rst),
    .ce         (ce),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .end_in     (end_in),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .frame_done (frame_done),
    .word_count (word_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every rd_valid pulse must match the head of the scoreboard.
  initial begin
    logic [N-1:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_valid_unexpected: got rd_valid=1 data=0x%0h expected no pulse at %0t",
                   rd_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", int'(rd_data), int'(e));
        end
      end
    end
  end

  // One clock cycle of stimulus; model is advanced for the same edge.
  task automatic step(input logic c, input logic v, input logic e,
                      input logic r, input logic [N-1:0] d);
    @(negedge clk);
    ce = c; valid_in = v; end_in = e; rd_en = r; data_in = d;
    if (c) begin
      if (!m_ready) begin
        if (v) begin
          if (mq.size() < DEPTH) mq.push_back(d);
          else                   m_ovf = 1'b1;
        end
        if (e && mq.size() != 0) m_ready = 1'b1;
      end else begin
        if (v) m_ovf = 1'b1;
        if (r && mq.size() != 0) begin
          exp_q.push_back(mq.pop_front());
          if (mq.size() == 0) m_ready = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("word_count", int'(word_count), mq.size());
    chk("frame_done", int'(frame_done), int'(m_ready));
    chk("overflow",   int'(overflow),   int'(m_ovf));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic push_word(input logic [N-1:0] d, input logic e);
    step(1'b1, 1'b1, e, 1'b0, d);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    idle();
    @(negedge clk);
    #2;
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    ce = 1'b0; valid_in = 1'b0; end_in = 1'b0; rd_en = 1'b0;
    global_rst = 1'b1;
    #1;
    chk("rst_word_count", int'(word_count), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overflow",   int'(overflow),   0);
    chk("rst_rd_valid",   int'(rd_valid),   0);
    chk("rst_rd_data",    int'(rd_data),    0);
    mq.delete();
    exp_q.delete();
    m_ready = 1'b0;
    m_ovf   = 1'b0;
    @(negedge clk);
    global_rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] vec [4];
    vec[0] = 16'h0400; vec[1] = 16'hFC00; vec[2] = 16'h0123; vec[3] = 16'h8001;

    repeat (2) @(posedge clk);
    #1;
    chk("init_word_count", int'(word_count), 0);
    chk("init_frame_done", int'(frame_done), 0);
    chk("init_overflow",   int'(overflow),   0);
    chk("init_rd_valid",   int'(rd_valid),   0);
    chk("init_rd_data",    int'(rd_data),    0);
    @(negedge clk);
    global_rst = 1'b0;

    // Capture and drain.
    for (int i = 0; i < 4; i++) push_word(vec[i], i == 3);
    chk("cd_frame_done", int'(frame_done), 1);
    chk("cd_word_count", int'(word_count), 4);
    drain(4);
    chk("cd_after_done",  int'(frame_done), 0);
    chk("cd_after_count", int'(word_count), 0);

    // Overflow: 17 words, end on the 17th; extra pop on empty has no effect.
    for (int i = 0; i < 17; i++) push_word(N'(i), i == 16);
    chk("ovf_count", int'(word_count), 16);
    chk("ovf_flag",  int'(overflow),   1);
    drain(17);

    // Word dropped while READY.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(vec[3-i], i == 3);
    push_word(16'hAAAA, 1'b0);
    chk("rdy_drop_ovf",   int'(overflow),   1);
    chk("rdy_drop_count", int'(word_count), 4);
    drain(4);

    // Clock-enable gating mid-capture.
    do_reset();
    push_word(16'h1111, 1'b0);
    push_word(16'h2222, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0] == 1'b0, 1'b0, 1'b1, 16'hDEAD);
      chk("ce_frozen_count", int'(word_count), 2);
      chk("ce_rd_valid",     int'(rd_valid),   0);
    end
    push_word(16'h3333, 1'b1);
    chk("ce_resume_count", int'(word_count), 3);
    drain(3);

    // Empty end is ignored; new word right after the last pop lands first.
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    chk("empty_end_done", int'(frame_done), 0);
    push_word(16'h0A0A, 1'b0);
    push_word(16'h0B0B, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    push_word(16'h5A5A, 1'b1);
    chk("rearm_count", int'(word_count), 1);
    drain(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, N'($urandom));
    drain(DEPTH + 1);

    // Async reset mid-drain.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(vec[i] ^ 16'h00FF, i == 3);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    do_reset();
    idle();
    @(negedge clk);
    #2;
    chk("final_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
